irq_encoder_4x2: RTL
====================

Name: irq_encoder_4x2

Overview:
- Inverse companion of the 2-to-4 active-low select decoder: takes four active-low request lines and returns a 2-bit binary index of the serviced request.
- Sits between asynchronous peripheral request lines and the processor control unit.
- Synchronizes the lines, latches each falling edge as a pending request, and presents the highest-priority pending index through a valid/ack handshake.
- Priority follows the decoder's mapping: index 0 (req_n[0]) is highest, index 3 is lowest.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops per request line (legal 2..4).

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
enable  input  1  high = new grants allowed; low = requests still latched but no new grant starts
req_n  input  4  asynchronous active-low request lines; a falling edge raises a request
ack  input  1  consumer accepts the presented code; sampled only while valid=1
valid  output  1  code holds a granted request index
code  output  2  binary index of the granted request (0..3)
pending  output  4  registered pending-request bits, active-high
multi  output  1  combinational; 1 when two or more pending bits are set

Behaviour:
- Reset is asynchronous on rst_n low and releases on clk.
  - Every synchronizer flop and edge-detect history flop resets to 1 (inactive).
  - pending=4'b0000, valid=0, code=2'b00, multi=0, FSM=IDLE.
  - Reset mid-handshake drops valid immediately and discards all pending requests.
- Synchronizer: each req_n bit passes through SYNC_STAGES flops. sync[i] is the last stage.
- Edge detect: hist[i] registers sync[i]. A fall is flagged when hist[i]=1 and sync[i]=0.
  - A line held low produces exactly one request.
  - A line must return high for at least one synchronized cycle before it can raise another request.
- Pending update, per bit, every edge: pending[i] <= fall[i] | (pending[i] & ~clr[i]).
  - clr[i] is 1 only on the ack-accept edge for i==code.
  - Set wins over clear: a fresh fall on the bit being acknowledged leaves it pending.
  - A fall on a bit that is already pending is absorbed (no count is kept).
- Latency: let E0 be the first clk edge that samples req_n[i]=0.
  - pending[i]=1 after edge E0+SYNC_STAGES.
  - If idle and enabled, valid=1 with code=i after edge E0+SYNC_STAGES+1.
- FSM, two states:
  - IDLE: valid=0. On an edge with enable=1 and pending!=0, register code = lowest set index of pending, set valid=1, go to GRANT. Otherwise stay. ack is ignored in IDLE.
  - GRANT: valid=1 and code held stable regardless of enable or new requests. On an edge with ack=1, clear pending[code], set valid=0, go to IDLE. Otherwise stay.
- Throughput: after an accept there is at least one IDLE cycle with valid=0 before the next grant. Maximum rate is one grant per 2 cycles when ack is returned in the same cycle valid rises.
- Priority is re-evaluated only in IDLE. A higher-priority request arriving during GRANT does not preempt; it is served next.
- enable=0 in GRANT does not withdraw the grant.
- code keeps its last value while valid=0; the consumer must not use it then.
- multi = popcount(pending) >= 2, taken from the pending register with no extra latency.

Test Plan:
- Reset: hold rst_n=0 with req_n=4'b0000 -> valid=0, pending=0000, code=00; after release with req_n held at 0000, no request is ever raised (no edge).
- Single request: req_n[2] 1->0 at E0, SYNC_STAGES=2 -> pending=0100 after E0+2; valid=1, code=10 after E0+3; ack=1 for one cycle -> valid=0, pending=0000 next edge.
- Priority: falls on req_n[3] and req_n[1] in the same cycle -> multi=1, first grant code=01, ack; IDLE gap of one cycle; second grant code=11, ack -> pending=0000.
- No preemption, set-beats-clear: grant code=11 held; req_n[0] falls -> code stays 11. Second bench: re-raise req_n[3] with its fall landing on the ack edge -> pending[3] stays 1, regranted code=11.
- Enable gating: enable=0 with req_n[1] fall -> pending=0010, valid stays 0 for 10 cycles; enable=1 -> valid=1, code=01 on the next edge.
- Async reset mid-GRANT: valid=1, code=10; drop rst_n between edges -> valid=0 and pending=0000 immediately, with no clock edge required.

Source files
------------

// File: rtl/irq_encoder_4x2.sv
// Four active-low async request lines -> synchronized, edge-latched,
// priority-encoded 2-bit index with a valid/ack handshake.
module irq_encoder_4x2 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] req_n,
  input  logic       ack,
  output logic       valid,
  output logic [1:0] code,
  output logic [3:0] pending,
  output logic       multi
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t state, state_nx;

  logic [3:0] stg [SYNC_STAGES];
  logic [3:0] sync;
  logic [3:0] hist;
  logic [3:0] fall;
  logic [3:0] clr;
  logic [1:0] pick;
  logic [SYNC_STAGES:0] live;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        stg[k] <= 4'hf;
    end else begin
      stg[0] <= req_n;
      for (int k = 1; k < SYNC_STAGES; k++)
        stg[k] <= stg[k-1];
    end
  end

  assign sync = stg[SYNC_STAGES-1];

  // live masks falls until both sync and hist carry post-reset samples,
  // so a line already low at reset release is not taken as a new edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 4'hf;
      live <= '0;
    end else begin
      hist <= sync;
      live <= {live[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign fall = hist & ~sync & {4{live[SYNC_STAGES]}};

  always_comb begin
    clr = 4'b0000;
    if (state == GRANT && ack)
      clr[code] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pending <= 4'b0000;
    else
      pending <= fall | (pending & ~clr);
  end

  always_comb begin
    pick = 2'd0;
    priority case (1'b1)
      pending[0]: pick = 2'd0;
      pending[1]: pick = 2'd1;
      pending[2]: pick = 2'd2;
      pending[3]: pick = 2'd3;
      default:    pick = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      code  <= 2'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && enable && |pending)
        code <= pick;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (enable && |pending) state_nx = GRANT;
      GRANT:   if (ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    valid = (state == GRANT);
  end

  assign multi = (pending & (pending - 4'd1)) != 4'd0;

endmodule
